// File: rtl/posit_defines_es3.sv
// Shared ES3 posit definitions: widths, the unpacked "value" record and its
// serialized form consumed by downstream ES3 arithmetic.
package posit_defines_es3;

    localparam int NBITS   = 32;
    localparam int ES      = 3;
    localparam int SCALE_W = 9;
    // Fraction holds every bit left after sign, the shortest regime and exponent.
    localparam int FRAC_W  = NBITS - ES - 3;
    localparam int POSIT_SERIALIZED_WIDTH_ES3 = 1 + SCALE_W + FRAC_W + 2;

    typedef struct packed {
        logic               sgn;
        logic [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]  fraction;
        logic               inf;
        logic               zero;
    } value;

    function automatic logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] serialize(input value v);
        return {v.sgn, v.scale, v.fraction, v.inf, v.zero};
    endfunction

endpackage

// File: rtl/posit_extract_raw_es3.sv
// Combinational ES3 raw extraction: sign, regime/exponent scale, fraction and
// the zero/NaR flags of a 32-bit posit, plus its two's-complement magnitude.
module posit_extract_raw_es3
    import posit_defines_es3::*;
(
    input  logic [NBITS-1:0]                      posit,
    output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] result,
    output logic [NBITS-2:0]                      absolute
);

    // Length of the run of bits equal to the leading regime bit.
    function automatic logic [5:0] regime_run(input logic [NBITS-2:0] bits);
        logic [5:0] n;
        logic       done;
        n    = 6'd1;
        done = 1'b0;
        for (int i = NBITS - 3; i >= 0; i--) begin
            if (!done && bits[i] == bits[NBITS-2]) n = n + 6'd1;
            else                                   done = 1'b1;
        end
        return n;
    endfunction

    logic [5:0]       run;
    logic [5:0]       k;
    logic [NBITS-4:0] tail;
    value             v;

    always_comb begin
        // Low bits of a negation depend only on low bits, so the sign bit is not needed.
        absolute = posit[NBITS-1] ? (~posit[NBITS-2:0] + 31'd1) : posit[NBITS-2:0];
        run      = regime_run(absolute);
        k        = absolute[NBITS-2] ? (run - 6'd1) : (6'd0 - run);
        // Drop the regime run and its terminator; exponent then fraction remain on top.
        tail     = absolute[NBITS-4:0] << (run - 6'd1);

        v          = '0;
        v.sgn      = posit[NBITS-1];
        v.scale    = {k, tail[NBITS-4:NBITS-6]};
        v.fraction = tail[FRAC_W-1:0];
        if (posit == '0) begin
            v      = '0;
            v.zero = 1'b1;
        end else if (posit == {1'b1, {(NBITS-1){1'b0}}}) begin
            v     = '0;
            v.sgn = 1'b1;
            v.inf = 1'b1;
        end
        result = serialize(v);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants a lone requester directly and breaks
// ties with a pointer that moves away from the last winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr;

    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = rr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values in parallel.
        if (reset)     rr <= 1'b0;
        else if (|gnt) rr <= ~gnt[1];
    end

endmodule

// File: rtl/posit_extract_arb_es3.sv
// Two-requester front end sharing one ES3 extraction datapath: round-robin
// arbitration into S1, extraction, S2 registers driving the output port.
module posit_extract_arb_es3
    import posit_defines_es3::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [NBITS-1:0]                      a_posit,
    input  logic [TAG_W-1:0]                      a_tag,
    input  logic                                  b_valid,
    output logic                                  b_ready,
    input  logic [NBITS-1:0]                      b_posit,
    input  logic [TAG_W-1:0]                      b_tag,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_id,
    output logic [TAG_W-1:0]                      out_tag,
    output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] out_result,
    output logic [NBITS-2:0]                      out_absolute
);

    logic                                  s1_valid;
    logic [NBITS-1:0]                      s1_posit;
    logic                                  s1_id;
    logic [TAG_W-1:0]                      s1_tag;
    logic                                  s2_load;
    logic                                  s1_free;
    logic [1:0]                            gnt;
    logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] ext_result;
    logic [NBITS-2:0]                      ext_absolute;

    // S1 may refill on the same edge S2 drains it, so a full pipe never bubbles.
    assign s2_load = s1_valid && (!out_valid || out_ready);
    assign s1_free = !s1_valid || s2_load;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({b_valid, a_valid}),
        .en    (s1_free),
        .gnt   (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_posit <= '0;
            s1_id    <= 1'b0;
            s1_tag   <= '0;
        end else if (|gnt) begin
            s1_valid <= 1'b1;
            s1_id    <= gnt[1];
            s1_posit <= gnt[1] ? b_posit : a_posit;
            s1_tag   <= gnt[1] ? b_tag : a_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    posit_extract_raw_es3 u_extract (
        .posit    (s1_posit),
        .result   (ext_result),
        .absolute (ext_absolute)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_id       <= 1'b0;
            out_tag      <= '0;
            out_result   <= '0;
            out_absolute <= '0;
        end else if (s2_load) begin
            out_valid    <= 1'b1;
            out_id       <= s1_id;
            out_tag      <= s1_tag;
            out_result   <= ext_result;
            out_absolute <= ext_absolute;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_posit_extract_arb_es3.sv
// Self-checking bench for posit_extract_arb_es3: directed vector table, corner
// sequences and random traffic, all results checked through a scoreboard queue.
module tb_posit_extract_arb_es3;
    import posit_defines_es3::*;

    localparam int TAG_W = 4;
    localparam int SW    = POSIT_SERIALIZED_WIDTH_ES3;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [31:0]      a_posit, b_posit;
    logic [TAG_W-1:0] a_tag, b_tag;
    logic             out_valid, out_ready, out_id;
    logic [TAG_W-1:0] out_tag;
    logic [SW-1:0]    out_result;
    logic [30:0]      out_absolute;

    always #5 clk = ~clk;

    posit_extract_arb_es3 #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_posit      (a_posit),
        .a_tag        (a_tag),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_posit      (b_posit),
        .b_tag        (b_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_tag      (out_tag),
        .out_result   (out_result),
        .out_absolute (out_absolute)
    );

    typedef struct {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [SW-1:0]    result;
        logic [30:0]      absolute;
    } exp_t;

    typedef struct {
        logic             pend;
        logic [31:0]      posit;
        logic [TAG_W-1:0] tag;
        logic [SW-1:0]    result;
        logic [30:0]      absolute;
    } req_t;

    typedef struct {
        logic             id;
        logic [31:0]      posit;
        logic [TAG_W-1:0] tag;
        logic [SW-1:0]    result;
        logic [30:0]      absolute;
    } vec_t;

    exp_t  sb[$];
    int    grant_log[$];
    req_t  rq[2];
    vec_t  vecs[12];
    int    n_vec = 0;
    int    n_err = 0;
    logic  ordy;
    logic  m_s1v, m_s2v, m_rr;
    logic  hold;
    logic [79:0] prev_out;

    task automatic check(input string name, input logic [79:0] actual, input logic [79:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [SW-1:0] mk(input logic sgn, input int scale, input logic [25:0] frac,
                                         input logic inf, input logic zero);
        logic [8:0] s;
        s = scale[8:0];
        return {sgn, s, frac, inf, zero};
    endfunction

    // Bit-walking reference decode of an ES3 posit.
    function automatic void model(input logic [31:0] p, output logic [SW-1:0] res, output logic [30:0] ab);
        logic [31:0] a;
        logic        r;
        logic [25:0] f;
        int          i, m, k, e;
        a  = p[31] ? (32'd0 - p) : p;
        ab = a[30:0];
        if (p == 32'd0) begin
            res = mk(1'b0, 0, 26'd0, 1'b0, 1'b1);
        end else if (p == 32'h8000_0000) begin
            res = mk(1'b1, 0, 26'd0, 1'b1, 1'b0);
        end else begin
            r = a[30];
            i = 30;
            while (i >= 0 && a[i] == r) i--;
            m = 30 - i;
            k = r ? m - 1 : -m;
            e = 0;
            for (int j = 1; j <= 3; j++) e = e * 2 + ((i - j >= 0) ? int'(a[i-j]) : 0);
            f = '0;
            for (int j = 4; j <= 29; j++) f = {f[24:0], (i - j >= 0) ? a[i-j] : 1'b0};
            res = mk(p[31], k * 8 + e, f, 1'b0, 1'b0);
        end
    endfunction

    task automatic send(input int port, input logic [31:0] p, input logic [TAG_W-1:0] t,
                        input logic [SW-1:0] res, input logic [30:0] ab);
        rq[port] = '{1'b1, p, t, res, ab};
    endtask

    task automatic send_rand(input int port);
        logic [31:0]   p;
        logic [SW-1:0] res;
        logic [30:0]   ab;
        case ($urandom_range(0, 9))
            0:       p = 32'd0;
            1:       p = 32'h8000_0000;
            2:       p = $urandom_range(0, 3);
            3:       p = 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: p = $urandom;
        endcase
        model(p, res, ab);
        send(port, p, TAG_W'($urandom), res, ab);
    endtask

    // One cycle: drive at negedge, sample 1ns later, book-keep what the next edge takes.
    task automatic step();
        logic       s2l, free;
        logic [1:0] eg;
        exp_t       e;
        @(negedge clk);
        a_valid   = rq[0].pend;
        a_posit   = rq[0].posit;
        a_tag     = rq[0].tag;
        b_valid   = rq[1].pend;
        b_posit   = rq[1].posit;
        b_tag     = rq[1].tag;
        out_ready = ordy;
        #1;
        s2l  = m_s1v && (!m_s2v || out_ready);
        free = !m_s1v || s2l;
        eg   = 2'b00;
        if (free) begin
            if (a_valid && b_valid) eg = m_rr ? 2'b10 : 2'b01;
            else                    eg = {b_valid, a_valid};
        end
        check("ready", {b_ready, a_ready}, eg);
        check("out_valid", out_valid, m_s2v);
        if (hold) check("hold_stable", {out_id, out_tag, out_result, out_absolute}, prev_out);
        hold     = out_valid && !out_ready;
        prev_out = {out_id, out_tag, out_result, out_absolute};
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                fail("unexpected_output");
            end else begin
                e = sb.pop_front();
                check("out", {out_id, out_tag, out_result, out_absolute},
                      {e.id, e.tag, e.result, e.absolute});
            end
        end
        if (a_valid && a_ready) begin
            sb.push_back('{1'b0, rq[0].tag, rq[0].result, rq[0].absolute});
            grant_log.push_back(0);
            rq[0].pend = 1'b0;
        end
        if (b_valid && b_ready) begin
            sb.push_back('{1'b1, rq[1].tag, rq[1].result, rq[1].absolute});
            grant_log.push_back(1);
            rq[1].pend = 1'b0;
        end
        m_s2v = s2l ? 1'b1 : (m_s2v && !out_ready);
        m_s1v = (|eg) ? 1'b1 : (s2l ? 1'b0 : m_s1v);
        if (|eg) m_rr = !eg[1];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        rq[0].pend = 1'b0;
        rq[1].pend = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        grant_log.delete();
        m_s1v = 1'b0;
        m_s2v = 1'b0;
        m_rr  = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((rq[0].pend || rq[1].pend || sb.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (rq[0].pend || rq[1].pend || sb.size() != 0) fail("drain_timeout");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n_a, n_b, budget;

        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_posit = '0;   b_posit = '0;
        a_tag = '0;     b_tag = '0;
        ordy = 1'b1;    out_ready = 1'b1;
        rq[0] = '{1'b0, 32'd0, '0, '0, '0};
        rq[1] = '{1'b0, 32'd0, '0, '0, '0};
        m_s1v = 1'b0; m_s2v = 1'b0; m_rr = 1'b0; hold = 1'b0; prev_out = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_id", out_id, 1'b0);
        check("rst_out_tag", out_tag, '0);
        check("rst_out_result", out_result, '0);
        check("rst_out_absolute", out_absolute, '0);

        // Directed extraction vectors with hand-derived results.
        vecs[0]  = '{1'b0, 32'h4000_0000, 4'd3,  mk(1'b0,    0, 26'h0,       1'b0, 1'b0), 31'h4000_0000};
        vecs[1]  = '{1'b0, 32'h6000_0000, 4'd1,  mk(1'b0,    8, 26'h0,       1'b0, 1'b0), 31'h6000_0000};
        vecs[2]  = '{1'b1, 32'hC000_0000, 4'd2,  mk(1'b1,    0, 26'h0,       1'b0, 1'b0), 31'h4000_0000};
        vecs[3]  = '{1'b1, 32'h0000_0000, 4'd4,  mk(1'b0,    0, 26'h0,       1'b0, 1'b1), 31'h0};
        vecs[4]  = '{1'b0, 32'h8000_0000, 4'd5,  mk(1'b1,    0, 26'h0,       1'b1, 1'b0), 31'h0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFF, 4'd6,  mk(1'b0,  240, 26'h0,       1'b0, 1'b0), 31'h7FFF_FFFF};
        vecs[6]  = '{1'b1, 32'h0000_0001, 4'd7,  mk(1'b0, -240, 26'h0,       1'b0, 1'b0), 31'h1};
        vecs[7]  = '{1'b0, 32'h4800_0000, 4'd8,  mk(1'b0,    2, 26'h0,       1'b0, 1'b0), 31'h4800_0000};
        vecs[8]  = '{1'b1, 32'h4000_0001, 4'd9,  mk(1'b0,    0, 26'h1,       1'b0, 1'b0), 31'h4000_0001};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 4'd10, mk(1'b1, -240, 26'h0,       1'b0, 1'b0), 31'h1};
        vecs[10] = '{1'b0, 32'h2000_0000, 4'd11, mk(1'b0,   -8, 26'h0,       1'b0, 1'b0), 31'h2000_0000};
        vecs[11] = '{1'b0, 32'h4080_0000, 4'd12, mk(1'b0,    0, 26'h0800000, 1'b0, 1'b0), 31'h4080_0000};

        for (int i = 0; i < 12; i++) begin
            send(int'(vecs[i].id), vecs[i].posit, vecs[i].tag, vecs[i].result, vecs[i].absolute);
            budget = 0;
            while (rq[vecs[i].id].pend && budget < 20) begin
                step();
                budget++;
            end
            lat = 0;
            while (!out_valid && lat < 10) begin
                step();
                lat++;
            end
            check("latency", lat, 2);
            wait_idle(20);
        end

        // Both requesters continuously valid: strict A/B alternation from A.
        do_reset();
        ordy = 1'b1;
        n_a = 0; n_b = 0;
        for (int c = 0; c < 40 && (n_a < 3 || n_b < 3 || rq[0].pend || rq[1].pend); c++) begin
            if (!rq[0].pend && n_a < 3) begin
                send(0, 32'h6000_0000, TAG_W'(n_a), mk(1'b0, 8, 26'h0, 1'b0, 1'b0), 31'h6000_0000);
                n_a++;
            end
            if (!rq[1].pend && n_b < 3) begin
                send(1, 32'hC000_0000, TAG_W'(8 + n_b), mk(1'b1, 0, 26'h0, 1'b0, 1'b0), 31'h4000_0000);
                n_b++;
            end
            step();
        end
        wait_idle(20);
        check("alt_count", grant_log.size(), 6);
        foreach (grant_log[i]) check("alt_order", grant_log[i], i % 2);

        // Special values presented together.
        send(1, 32'h0000_0000, 4'd5, mk(1'b0, 0, 26'h0, 1'b0, 1'b1), 31'h0);
        send(0, 32'h8000_0000, 4'd6, mk(1'b1, 0, 26'h0, 1'b1, 1'b0), 31'h0);
        wait_idle(20);

        // Back-pressure: two grants fill the pipe, then everything holds.
        do_reset();
        ordy = 1'b0;
        n_a = 0; n_b = 0;
        for (int c = 0; c < 12; c++) begin
            if (!rq[0].pend && n_a < 4) begin send_rand(0); n_a++; end
            if (!rq[1].pend && n_b < 4) begin send_rand(1); n_b++; end
            step();
        end
        check("bp_grants", grant_log.size(), 2);
        ordy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (!rq[0].pend && n_a < 4) begin send_rand(0); n_a++; end
            if (!rq[1].pend && n_b < 4) begin send_rand(1); n_b++; end
            step();
            check("bp_throughput", out_valid, 1'b1);
        end
        for (int c = 0; c < 20 && (n_a < 4 || n_b < 4); c++) begin
            if (!rq[0].pend && n_a < 4) begin send_rand(0); n_a++; end
            if (!rq[1].pend && n_b < 4) begin send_rand(1); n_b++; end
            step();
        end
        wait_idle(30);
        check("bp_total", grant_log.size(), 8);

        // Reset with both stages full discards them; the pointer restarts at A.
        do_reset();
        ordy = 1'b0;
        send_rand(0);
        send_rand(1);
        repeat (4) step();
        check("full_before_reset", out_valid, 1'b1);
        do_reset();
        #1;
        check("rst2_out_valid", out_valid, 1'b0);
        check("rst2_out_result", {out_id, out_tag, out_result, out_absolute}, '0);
        ordy = 1'b1;
        send_rand(0);
        send_rand(1);
        wait_idle(20);
        check("rst2_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("rst2_first_grant", grant_log[0], 0);
        else                      fail("rst2_first_grant");

        // Random valid/ready traffic.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            if (!rq[0].pend && $urandom_range(0, 2) != 0) send_rand(0);
            if (!rq[1].pend && $urandom_range(0, 2) != 0) send_rand(1);
            step();
        end
        ordy = 1'b1;
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/posit_extract_arb_es3.md
# posit_extract_arb_es3

Two-requester front end that shares one ES3 posit raw-extraction datapath between two independent producers, e.g. the two operand ports of an accumulator. Round-robin arbitration, valid/ready handshakes on every port, and a two-stage registered pipeline around the combinational extraction logic. Sits between operand sources and downstream ES3 arithmetic that consumes the serialized `value` format.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried with each request.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A has a posit.
- `a_ready`  out  1  requester A accepted this cycle.
- `a_posit`  in  32  requester A posit.
- `a_tag`  in  TAG_W  requester A tag.
- `b_valid`, `b_ready`, `b_posit`, `b_tag`: same as A, for requester B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_id`  out  1  source requester (0 = A, 1 = B).
- `out_tag`  out  TAG_W  tag of the source request.
- `out_result`  out  POSIT_SERIALIZED_WIDTH_ES3  serialized sgn/scale/fraction/inf/zero.
- `out_absolute`  out  31  magnitude bits of the two's-complement-negated input.

## Operation
- Handshake:
  - Transfer on any port when valid && ready, sampled at the rising edge.
  - Requesters hold `*_posit` and `*_tag` stable while valid && !ready.
  - `*_ready` is a combinational function of `*_valid`, the pointer and pipeline occupancy, never of itself.
- Stages:
  - S1 registers posit, id and tag.
  - The combinational extraction reads S1.
  - S2 registers `result`, `absolute`, id and tag.
  - S2 drives the `out_*` ports.
- Advance rules:
  - `s2_load = s1_valid && (!s2_valid || out_ready)`.
  - `s1_free = !s1_valid || s2_load`.
- Arbitration:
  - Only when `s1_free`.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one selected by pointer `rr` (0 = A).
  - At most one `*_ready` is high per cycle.
- Pointer update: on every grant, `rr` ← not(granted id). With both requesters continuously valid, grants strictly alternate.
- No grant when `s1_free` = 0; both readies stay low.
- Extraction semantics:
  - 0x00000000 → zero = 1.
  - 0x80000000 → inf = 1, sgn = 1.
  - Negative inputs are negated before regime decode.
  - scale = k·8 + exponent, in 9-bit two's complement.
- Reset clears `s1_valid`, `s2_valid` and `rr`. All `out_*` data registers also reset to 0, so after reset `out_valid` = 0, `out_id` = 0, `out_tag` = 0, `out_result` = 0 and `out_absolute` = 0.
- Reset mid-operation discards in-flight requests; nothing is replayed.

## Timing
- Latency: a grant at edge N appears on `out_*` with `out_valid` = 1 after edge N+1, i.e. 2 cycles.
- Throughput: 1 result per cycle while `out_ready` = 1.
- Back-pressure with both stages full and `out_ready` = 0:
  - Both readies low.
  - S1 and S2 hold their contents.
- `out_ready` rising while full:
  - S2 takes S1 and S1 takes a new grant on the same edge.
  - No bubble is inserted.
- Simultaneous `a_valid` and `b_valid` in the first cycle after reset: A is granted (`rr` = 0).
- `out_*` data are stable while `out_valid` && !`out_ready`.

## Structure
- Shared package `posit_defines_es3` supplies:
  - `NBITS`, `ES`, `POSIT_SERIALIZED_WIDTH_ES3`;
  - the `value` struct and `serialize`.
- No new package types are needed. `TAG_W` stays a module parameter.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with `clk`, `reset`, `req[1:0]`, `en`, `gnt[1:0]` and an internal pointer.
- The ES3 extraction datapath is instantiated unchanged between S1 and S2.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset, then A sends 0x40000000 (tag 3) with `out_ready` = 1 → after 2 cycles: `out_id` = 0, `out_tag` = 3, sgn = 0, scale = 0, fraction = 0, `out_absolute` = 0x40000000.
- A and B both valid continuously; A sends 0x60000000, B sends 0xC0000000 → first result id 0 with scale = 8, then id 1 with sgn = 1 and scale = 0, then strict alternation A, B, A, B.
- Special values 0x00000000 from B and 0x80000000 from A → zero = 1 for the B result; inf = 1 and sgn = 1 for the A result; ids correct.
- Hold `out_ready` = 0 with both valid → exactly 2 grants, then both readies low; `out_*` stable for 10 cycles; release → 1 result per cycle, no loss or duplication, order preserved.
- Assert `reset` for 1 cycle with both stages full → next cycle `out_valid` = 0 and `rr` = 0; the next simultaneous request grants A.
- Random valid/ready traffic for 10k cycles against a scoreboard → every accepted (id, tag, posit) appears exactly once, in order, with correct extraction.
